// File: rtl/cordic_rr_scheduler.sv
// Round-robin, credit-gated front end that shares one non-stallable CORDIC
// vectoring core among N_REQ requesters and returns results via per-requester FIFOs.
module cordic_rr_scheduler #(
    parameter int WIDTH      = 16,
    parameter int N_REQ      = 2,
    parameter int PIPE_LAT   = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [WIDTH-1:0]       core_x,
    output logic [WIDTH-1:0]       core_y,
    input  logic [WIDTH-1:0]       core_mag,
    input  logic [31:0]            core_phase,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [N_REQ*WIDTH-1:0] rsp_mag,
    output logic [N_REQ*32-1:0]    rsp_phase,
    output logic                   busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = WIDTH + 32;

    logic [PW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    credit_q [N_REQ];
    logic [CW-1:0]    credit_d [N_REQ];
    logic [PIPE_LAT:0] tag_v_q, tag_v_d;
    logic [PW-1:0]    tag_id_q [PIPE_LAT+1];
    logic [PW-1:0]    tag_id_d [PIPE_LAT+1];
    logic [WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d;
    logic [DW-1:0]    mem_q [N_REQ][FIFO_DEPTH];
    logic [DW-1:0]    mem_d [N_REQ][FIFO_DEPTH];
    logic [AW-1:0]    rd_q [N_REQ];
    logic [AW-1:0]    rd_d [N_REQ];
    logic [AW-1:0]    wr_q [N_REQ];
    logic [AW-1:0]    wr_d [N_REQ];
    logic [CW-1:0]    cnt_q [N_REQ];
    logic [CW-1:0]    cnt_d [N_REQ];
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] elig, grant, push, pop, nonempty, nonempty_d;
    logic [PW-1:0]    grant_id;
    logic [PW-1:0]    idx;
    logic             issue;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(FIFO_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (credit_q[i] != '0);
        end
    end

    // Scan downward so the last hit is the first eligible requester from rr_q.
    always_comb begin
        grant_id = '0;
        idx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_q) + k) % N_REQ);
            if (elig[idx]) grant_id = idx;
        end
        issue = (|elig) && !rst;
        grant = issue ? (N_REQ'(1) << grant_id) : '0;
        if (!issue) begin
            rr_d = rr_q;
        end else if (grant_id == PW'(N_REQ - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = grant_id + 1'b1;
        end
    end

    always_comb begin
        core_x_d = core_x_q;
        core_y_d = core_y_q;
        if (issue) begin
            core_x_d = req_x[grant_id*WIDTH +: WIDTH];
            core_y_d = req_y[grant_id*WIDTH +: WIDTH];
        end
        tag_v_d     = {tag_v_q[PIPE_LAT-1:0], issue};
        tag_id_d[0] = grant_id;
        for (int k = 1; k <= PIPE_LAT; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    // The final tag stage lines up with the core output of the matching issue.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < N_REQ; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            push[i]     = tag_v_q[PIPE_LAT] && (tag_id_q[PIPE_LAT] == PW'(i));
            pop[i]      = nonempty[i] && rsp_ready[i];
            rd_d[i]     = pop[i]  ? ptr_inc(rd_q[i]) : rd_q[i];
            wr_d[i]     = push[i] ? ptr_inc(wr_q[i]) : wr_q[i];
            if (push[i]) mem_d[i][wr_q[i]] = {core_mag, core_phase};
            cnt_d[i]      = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            nonempty_d[i] = (cnt_d[i] != '0);
            credit_d[i]   = credit_q[i] - CW'(issue && (grant_id == PW'(i))) + CW'(pop[i]);
        end
        busy_d = (|tag_v_d) || (|nonempty_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= '0;
            tag_v_q  <= '0;
            core_x_q <= '0;
            core_y_q <= '0;
            busy_q   <= 1'b0;
            for (int k = 0; k <= PIPE_LAT; k++) tag_id_q[k] <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= CW'(FIFO_DEPTH);
                cnt_q[i]    <= '0;
                rd_q[i]     <= '0;
                wr_q[i]     <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            core_x_q <= core_x_d;
            core_y_q <= core_y_d;
            busy_q   <= busy_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rsp_mag[i*WIDTH +: WIDTH] = nonempty[i] ? mem_q[i][rd_q[i]][DW-1:32] : '0;
            rsp_phase[i*32 +: 32]     = nonempty[i] ? mem_q[i][rd_q[i]][31:0] : '0;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = nonempty;
    assign core_x    = core_x_q;
    assign core_y    = core_y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: stand-in CORDIC pipeline plus a queue-based
// transaction model of arbitration, credits and per-requester result ordering.
module tb_cordic_rr_scheduler;

    localparam int WIDTH      = 16;
    localparam int N_REQ      = 4;
    localparam int PIPE_LAT   = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int DW         = WIDTH + 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x = '0;
    logic [N_REQ*WIDTH-1:0] req_y = '0;
    logic [WIDTH-1:0]       core_x, core_y, core_mag;
    logic [31:0]            core_phase;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready = '0;
    logic [N_REQ*WIDTH-1:0] rsp_mag;
    logic [N_REQ*32-1:0]    rsp_phase;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_rr_scheduler #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .core_x(core_x), .core_y(core_y), .core_mag(core_mag), .core_phase(core_phase),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mag(rsp_mag),
        .rsp_phase(rsp_phase), .busy(busy)
    );

    // Stand-in core: arbitrary deterministic function, PIPE_LAT clocks deep.
    function automatic logic [DW-1:0] core_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] m;
        logic [31:0]      p;
        m = x + (y ^ 16'h3c3c);
        p = {y ^ x, x} ^ 32'h0f0f_1234;
        return {m, p};
    endfunction

    logic [DW-1:0] core_pipe [PIPE_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_f(core_x, core_y);
        for (int k = 1; k < PIPE_LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_mag   = core_pipe[PIPE_LAT-1][DW-1:32];
    assign core_phase = core_pipe[PIPE_LAT-1][31:0];

    // ---------------- transaction model ----------------
    typedef struct {
        int            arrive;
        int            id;
        logic [DW-1:0] res;
    } fly_t;

    int               m_ptr;
    int               m_edge;
    int               m_credit [N_REQ];
    logic [DW-1:0]    m_fifo [N_REQ][$];
    fly_t             m_fly [$];
    logic [WIDTH-1:0] m_cx, m_cy;

    task automatic m_reset();
        m_ptr = 0;
        m_cx  = '0;
        m_cy  = '0;
        m_fly.delete();
        for (int i = 0; i < N_REQ; i++) begin
            m_credit[i] = FIFO_DEPTH;
            m_fifo[i].delete();
        end
    endtask

    function automatic int exp_grant();
        if (rst) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i = (m_ptr + k) % N_REQ;
            if (req_valid[i] && m_credit[i] > 0) return i;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] exp_ready();
        logic [N_REQ-1:0] r = '0;
        int g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] exp_valid();
        logic [N_REQ-1:0] r = '0;
        for (int i = 0; i < N_REQ; i++) r[i] = (m_fifo[i].size() != 0);
        return r;
    endfunction

    function automatic logic [N_REQ*WIDTH-1:0] exp_mag();
        logic [N_REQ*WIDTH-1:0] r = '0;
        for (int i = 0; i < N_REQ; i++)
            if (m_fifo[i].size() != 0) r[i*WIDTH +: WIDTH] = m_fifo[i][0][DW-1:32];
        return r;
    endfunction

    function automatic logic [N_REQ*32-1:0] exp_phase();
        logic [N_REQ*32-1:0] r = '0;
        for (int i = 0; i < N_REQ; i++)
            if (m_fifo[i].size() != 0) r[i*32 +: 32] = m_fifo[i][0][31:0];
        return r;
    endfunction

    function automatic logic exp_busy();
        logic b = (m_fly.size() != 0);
        for (int i = 0; i < N_REQ; i++) if (m_fifo[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_edge();
        int g;
        if (rst) begin
            m_reset();
            return;
        end
        g = exp_grant();
        m_edge++;
        for (int i = 0; i < N_REQ; i++) begin
            if (m_fifo[i].size() != 0 && rsp_ready[i]) begin
                void'(m_fifo[i].pop_front());
                m_credit[i]++;
            end
        end
        if (g >= 0) begin
            fly_t f;
            f.arrive = m_edge + PIPE_LAT + 1;
            f.id     = g;
            f.res    = core_f(req_x[g*WIDTH +: WIDTH], req_y[g*WIDTH +: WIDTH]);
            m_fly.push_back(f);
            m_credit[g]--;
            m_ptr = (g + 1) % N_REQ;
            m_cx  = req_x[g*WIDTH +: WIDTH];
            m_cy  = req_y[g*WIDTH +: WIDTH];
        end
        while (m_fly.size() != 0 && m_fly[0].arrive == m_edge) begin
            m_fifo[m_fly[0].id].push_back(m_fly[0].res);
            void'(m_fly.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int onehot_id(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_x     = {N_REQ{16'h1234}};
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready: got %b exp 0", req_ready);
        end
        tick();
        tick();
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || core_x !== '0 || core_y !== '0) begin
            failures++;
            $display("FAIL reset_state: rsp_valid=%b busy=%b core_x=%h core_y=%h exp all 0",
                     rsp_valid, busy, core_x, core_y);
        end
        checks++;
        if (rsp_mag !== '0 || rsp_phase !== '0) begin
            failures++;
            $display("FAIL reset_rsp_data: mag=%h phase=%h exp 0", rsp_mag, rsp_phase);
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        int n;
        logic [DW-1:0] want;
        want      = core_f(16'd1000, 16'd0);
        req_x     = '0;
        req_y     = '0;
        req_x[15:0] = 16'd1000;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_accept: got %b exp 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (core_x !== 16'd1000 || core_y !== 16'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_core_in: core_x=%0d core_y=%0d busy=%b exp 1000 0 1",
                     core_x, core_y, busy);
        end
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            tick();
            n++;
        end
        #1;
        checks++;
        if (n !== PIPE_LAT + 1) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles exp %0d", n, PIPE_LAT + 1);
        end
        checks++;
        if (rsp_mag[15:0] !== want[DW-1:32] || rsp_phase[31:0] !== want[31:0]) begin
            failures++;
            $display("FAIL single_result: mag=%h phase=%h exp %h %h",
                     rsp_mag[15:0], rsp_phase[31:0], want[DW-1:32], want[31:0]);
        end
        checks++;
        if (rsp_valid[N_REQ-1:1] !== '0) begin
            failures++;
            $display("FAIL single_other_valid: got %b exp 0", rsp_valid[N_REQ-1:1]);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            failures++;
            $display("FAIL single_drain: busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_contention();
        int grants [$];
        reset_pulse();
        req_valid = 4'b0011;
        rsp_ready = '1;
        for (int c = 0; c < 80; c++) begin
            req_x = {$urandom, $urandom};
            req_y = {$urandom, $urandom};
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL cont_ready c=%0d: got %b exp %b", c, req_ready, exp_ready());
            end
            checks++;
            if (rsp_valid !== exp_valid() || rsp_mag !== exp_mag() || rsp_phase !== exp_phase()) begin
                failures++;
                $display("FAIL cont_rsp c=%0d: valid=%b mag=%h exp valid=%b mag=%h",
                         c, rsp_valid, rsp_mag, exp_valid(), exp_mag());
            end
            if (req_ready != '0) grants.push_back(onehot_id(req_ready));
            tick();
        end
        req_valid = '0;
        checks++;
        if (grants.size() < 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
            failures++;
            $display("FAIL cont_order: got %p exp 0,1,0,1 first", grants);
        end
        repeat (25) tick();
    endtask

    task automatic test_credit_stall();
        int acc;
        reset_pulse();
        req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL stall_ready c=%0d: got %b exp %b", c, req_ready, exp_ready());
            end
            if (req_ready[0]) acc++;
            tick();
        end
        checks++;
        if (acc != FIFO_DEPTH) begin
            failures++;
            $display("FAIL stall_accepts: got %0d exp %0d", acc, FIFO_DEPTH);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL stall_release: got %b exp 0001", req_ready);
        end
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready[0]) acc++;
            tick();
        end
        checks++;
        if (acc != 1) begin
            failures++;
            $display("FAIL stall_one_more: got %0d exp 1", acc);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (25) tick();
        rsp_ready = '0;
    endtask

    task automatic test_issue_pop();
        reset_pulse();
        req_x[15:0] = 16'h0aaa;
        req_valid   = 4'b0001;
        tick();
        req_valid = '0;
        repeat (PIPE_LAT + 3) tick();
        req_x[15:0] = 16'h0bbb;
        req_valid   = 4'b0001;
        rsp_ready   = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL ip_same_edge: ready=%b valid=%b exp 0001 1", req_ready, rsp_valid[0]);
        end
        tick();
        rsp_ready = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || req_ready !== exp_ready()) begin
            failures++;
            $display("FAIL ip_credit_kept: got %b exp 0001", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL ip_credit_zero: got %b exp 0000", req_ready);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (25) tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset_midflight();
        int acc;
        reset_pulse();
        req_valid = 4'b0011;
        tick();
        tick();
        req_valid = '0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy);
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (rsp_valid !== '0) begin
                failures++;
                $display("FAIL mid_stale c=%0d: rsp_valid=%b exp 0", c, rsp_valid);
            end
            tick();
        end
        req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (req_ready[0]) acc++;
            tick();
        end
        checks++;
        if (acc != FIFO_DEPTH) begin
            failures++;
            $display("FAIL mid_credits: accepts=%0d exp %0d", acc, FIFO_DEPTH);
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (25) tick();
        rsp_ready = '0;
    endtask

    task automatic test_wrap();
        int grants [$];
        reset_pulse();
        rsp_ready = '1;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL wrap_ready c=%0d: got %b exp %b", c, req_ready, exp_ready());
            end
            if (req_ready != '0) grants.push_back(onehot_id(req_ready));
            tick();
        end
        req_valid = '0;
        checks++;
        if (grants.size() < 4 || grants[0] != 3 || grants[1] != 0 || grants[2] != 3 || grants[3] != 0) begin
            failures++;
            $display("FAIL wrap_order: got %p exp 3,0,3,0 first", grants);
        end
        repeat (25) tick();
        rsp_ready = '0;
    endtask

    task automatic test_random();
        reset_pulse();
        for (int c = 0; c < 600; c++) begin
            req_valid = N_REQ'($urandom);
            rsp_ready = N_REQ'($urandom | $urandom);
            req_x     = {$urandom, $urandom};
            req_y     = {$urandom, $urandom};
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rnd_ready c=%0d: got %b exp %b", c, req_ready, exp_ready());
            end
            checks++;
            if (rsp_valid !== exp_valid() || rsp_mag !== exp_mag() || rsp_phase !== exp_phase()) begin
                failures++;
                $display("FAIL rnd_rsp c=%0d: valid=%b mag=%h exp valid=%b mag=%h",
                         c, rsp_valid, rsp_mag, exp_valid(), exp_mag());
            end
            checks++;
            if (busy !== exp_busy() || core_x !== m_cx || core_y !== m_cy) begin
                failures++;
                $display("FAIL rnd_busy_core c=%0d: busy=%b x=%h y=%h exp %b %h %h",
                         c, busy, core_x, core_y, exp_busy(), m_cx, m_cy);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (30) tick();
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            failures++;
            $display("FAIL rnd_drain: busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid);
        end
    endtask

    initial begin
        m_edge = 0;
        m_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_credit_stall();
        test_issue_pop();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
